// File: rtl/sram_ctrl_pkg.sv
// Shared types and Bennett phase assignments for the SRAM bank sequencer.
package sram_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        W_ADDR,
        W_DATA,
        W_EN,
        W_HOLD,
        W_DROP,
        W_CAP,
        RESP
    } state_t;

    localparam int PH_ADDR = 2;
    localparam int PH_DATA = 4;
    localparam int PH_EN   = 6;
    localparam int PH_WEN  = 8;
    localparam int PH_WOFF = 9;
    localparam int PH_CAP  = 0;

endpackage

// File: rtl/sram_bank_ctrl_if.sv
// Request/response bus of the SRAM bank controller.
// Handshake: a beat transfers on a clk edge where valid and ready are both high;
// valid and its payload stay stable until that edge, ready may toggle freely.
interface sram_bank_ctrl_if #(
    parameter int AW = 5,
    parameter int DW = 16
);
    logic          req_valid;
    logic          req_ready;
    logic          req_write;
    logic [AW-1:0] req_addr_a;
    logic [AW-1:0] req_addr_b;
    logic [DW-1:0] req_wdata;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [DW-1:0] rsp_data_a;
    logic [DW-1:0] rsp_data_b;
    logic          wr_done;

    modport master (
        output req_valid, req_write, req_addr_a, req_addr_b, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_data_a, rsp_data_b, wr_done
    );

    modport slave (
        input  req_valid, req_write, req_addr_a, req_addr_b, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_data_a, rsp_data_b, wr_done
    );

endinterface

// File: rtl/phase_edge_det.sv
// Registers the Bennett phase bus on clk and reports per-phase rising/falling events.
module phase_edge_det #(
    parameter int WIDTH = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] clkp,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall
);

    logic [WIDTH-1:0] clkp_q;

    always_ff @(posedge clk) begin
        if (reset) clkp_q <= '0;
        else       clkp_q <= clkp;
    end

    assign rise = clkp & ~clkp_q;
    assign fall = ~clkp & clkp_q;

endmodule

// File: rtl/sram_bank_ctrl.sv
// Sequences SRAM bank reads and writes against Bennett clock phase events,
// one request per phase frame, with a held read response.
module sram_bank_ctrl
    import sram_ctrl_pkg::*;
#(
    parameter int WIDTH = 10,
    parameter int AW    = 5,
    parameter int DW    = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] clkp,
    sram_bank_ctrl_if.slave  bus,
    output logic [AW-1:0]    Addr_A,
    output logic [AW-1:0]    Addr_B,
    output logic [DW-1:0]    in_data,
    output logic             ReadEn,
    output logic             WriteEn,
    output logic             RegWrtBar,
    input  logic [DW-1:0]    outA,
    input  logic [DW-1:0]    outB,
    output state_t           dbg_state
);

    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;

    phase_edge_det #(.WIDTH(WIDTH)) u_edge (
        .clk   (clk),
        .reset (reset),
        .clkp  (clkp),
        .rise  (rise),
        .fall  (fall)
    );

    // Only a handful of phases drive the sequence; the rest are deliberately ignored.
    logic unused_phase;
    assign unused_phase = ^{rise, fall};

    state_t        state, state_d;
    logic          wr_q, wr_d;
    logic [AW-1:0] la_q, la_d, lb_q, lb_d;
    logic [DW-1:0] wd_q, wd_d;
    logic [AW-1:0] addr_a_q, addr_a_d, addr_b_q, addr_b_d;
    logic [DW-1:0] in_data_q, in_data_d;
    logic          ren_q, ren_d, wen_q, wen_d, rwb_q, rwb_d;
    logic          rsp_valid_q, rsp_valid_d;
    logic [DW-1:0] rsp_a_q, rsp_a_d, rsp_b_q, rsp_b_d;
    logic          wr_done_q, wr_done_d;
    logic          accept;

    assign bus.req_ready  = (state == IDLE) && !rsp_valid_q;
    assign accept         = bus.req_valid && bus.req_ready;
    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_data_a = rsp_a_q;
    assign bus.rsp_data_b = rsp_b_q;
    assign bus.wr_done    = wr_done_q;

    assign Addr_A    = addr_a_q;
    assign Addr_B    = addr_b_q;
    assign in_data   = in_data_q;
    assign ReadEn    = ren_q;
    assign WriteEn   = wen_q;
    assign RegWrtBar = rwb_q;
    assign dbg_state = state;

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            wr_q        <= 1'b0;
            la_q        <= '0;
            lb_q        <= '0;
            wd_q        <= '0;
            addr_a_q    <= '0;
            addr_b_q    <= '0;
            in_data_q   <= '0;
            ren_q       <= 1'b0;
            wen_q       <= 1'b0;
            rwb_q       <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_a_q     <= '0;
            rsp_b_q     <= '0;
            wr_done_q   <= 1'b0;
        end else begin
            state       <= state_d;
            wr_q        <= wr_d;
            la_q        <= la_d;
            lb_q        <= lb_d;
            wd_q        <= wd_d;
            addr_a_q    <= addr_a_d;
            addr_b_q    <= addr_b_d;
            in_data_q   <= in_data_d;
            ren_q       <= ren_d;
            wen_q       <= wen_d;
            rwb_q       <= rwb_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_a_q     <= rsp_a_d;
            rsp_b_q     <= rsp_b_d;
            wr_done_q   <= wr_done_d;
        end
    end

    // Each state reacts to exactly one phase event; anything else waits.
    always_comb begin
        state_d = state;
        unique case (state)
            IDLE:   if (accept)          state_d = W_ADDR;
            W_ADDR: if (rise[PH_ADDR])   state_d = W_DATA;
            W_DATA: if (rise[PH_DATA])   state_d = W_EN;
            W_EN:   if (rise[PH_EN])     state_d = W_HOLD;
            W_HOLD: begin
                if (wr_q) begin
                    if (wen_q && rise[PH_WOFF]) state_d = W_DROP;
                end else if (rise[PH_WEN]) begin
                    state_d = W_CAP;
                end
            end
            W_DROP: if (fall[PH_EN])     state_d = IDLE;
            W_CAP:  if (fall[PH_CAP])    state_d = RESP;
            RESP:   if (bus.rsp_ready)   state_d = IDLE;
            default:                     state_d = IDLE;
        endcase
    end

    always_comb begin
        wr_d        = wr_q;
        la_d        = la_q;
        lb_d        = lb_q;
        wd_d        = wd_q;
        addr_a_d    = addr_a_q;
        addr_b_d    = addr_b_q;
        in_data_d   = in_data_q;
        ren_d       = ren_q;
        wen_d       = wen_q;
        rwb_d       = rwb_q;
        rsp_valid_d = rsp_valid_q;
        rsp_a_d     = rsp_a_q;
        rsp_b_d     = rsp_b_q;
        wr_done_d   = 1'b0;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    wr_d = bus.req_write;
                    la_d = bus.req_addr_a;
                    lb_d = bus.req_addr_b;
                    wd_d = bus.req_wdata;
                end
            end
            W_ADDR: begin
                if (rise[PH_ADDR]) begin
                    addr_a_d = la_q;
                    addr_b_d = lb_q;
                end
            end
            W_DATA: begin
                if (rise[PH_DATA] && wr_q) in_data_d = wd_q;
            end
            W_EN: begin
                if (rise[PH_EN]) begin
                    if (wr_q) rwb_d = 1'b1;
                    else      ren_d = 1'b1;
                end
            end
            W_HOLD: begin
                if (wr_q) begin
                    if (rise[PH_WEN])               wen_d = 1'b1;
                    else if (wen_q && rise[PH_WOFF]) wen_d = 1'b0;
                end else if (rise[PH_WEN]) begin
                    ren_d = 1'b0;
                end
            end
            W_DROP: begin
                if (fall[PH_EN]) begin
                    rwb_d     = 1'b0;
                    wr_done_d = 1'b1;
                end
            end
            W_CAP: begin
                if (fall[PH_CAP]) begin
                    rsp_a_d     = outA;
                    rsp_b_d     = outB;
                    rsp_valid_d = 1'b1;
                end
            end
            RESP: begin
                if (bus.rsp_ready) rsp_valid_d = 1'b0;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_sram_bank_ctrl.sv
// Bench for sram_bank_ctrl: Bennett frame driver, SRAM bank model, read scoreboard.
module tb_sram_bank_ctrl;
    import sram_ctrl_pkg::*;

    localparam int WIDTH = 10;
    localparam int AW    = 5;
    localparam int DW    = 16;
    localparam int HOLD  = 2;
    localparam int VW    = 2 * AW + DW + 4;

    // clock / reset
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic [WIDTH-1:0] clkp = '0;
    always #5 clk = ~clk;

    logic [AW-1:0] Addr_A, Addr_B;
    logic [DW-1:0] in_data, outA, outB;
    logic ReadEn, WriteEn, RegWrtBar;
    state_t dbg_state;

    sram_bank_ctrl_if #(.AW(AW), .DW(DW)) bus ();

    sram_bank_ctrl #(.WIDTH(WIDTH), .AW(AW), .DW(DW)) dut (
        .clk       (clk),
        .reset     (reset),
        .clkp      (clkp),
        .bus       (bus.slave),
        .Addr_A    (Addr_A),
        .Addr_B    (Addr_B),
        .in_data   (in_data),
        .ReadEn    (ReadEn),
        .WriteEn   (WriteEn),
        .RegWrtBar (RegWrtBar),
        .outA      (outA),
        .outB      (outB),
        .dbg_state (dbg_state)
    );

    // SRAM bank model: writes port A while the write strobe is up.
    logic [DW-1:0] bank [32] = '{default: '0};
    always @(posedge clk) if (WriteEn && RegWrtBar) bank[Addr_A] <= in_data;
    assign outA = bank[Addr_A];
    assign outB = bank[Addr_B];

    int errors = 0;
    int checks = 0;
    int wr_done_cnt = 0;
    logic [2*DW-1:0] exp_q[$];
    logic [DW-1:0] shadow [32];
    logic [AW-1:0] last_a = '0, last_b = '0;
    logic [DW-1:0] last_d = '0;

    logic [VW-1:0] out_vec;
    assign out_vec = {Addr_A, Addr_B, in_data, ReadEn, WriteEn, RegWrtBar, bus.rsp_valid};

    always @(posedge clk) begin
        #2;
        if (bus.wr_done) wr_done_cnt++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    // driver tasks
    task automatic do_step(input int s);
        if (s < 10) clkp[s] = 1'b1;
        else        clkp[19 - s] = 1'b0;
        repeat (HOLD) @(negedge clk);
    endtask

    task automatic issue_req(input logic w, input logic [AW-1:0] a, input logic [AW-1:0] b,
                             input logic [DW-1:0] d);
        int waited = 0;
        bus.req_write  = w;
        bus.req_addr_a = a;
        bus.req_addr_b = b;
        bus.req_wdata  = d;
        bus.req_valid  = 1'b1;
        while (!bus.req_ready && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        checks++;
        if (bus.req_ready !== 1'b1) begin
            errors++;
            $display("FAIL req_accept: req_ready=%b after %0d cycles, required 1", bus.req_ready, waited);
            bus.req_valid = 1'b0;
            return;
        end
        @(negedge clk);
        bus.req_valid = 1'b0;
        if (w) shadow[a] = d;
        else   exp_q.push_back({shadow[a], shadow[b]});
    endtask

    // Runs one full Bennett frame for a request already waiting in the controller.
    task automatic run_frame(input string tag, input logic w, input logic [AW-1:0] a,
                             input logic [AW-1:0] b, input logic [DW-1:0] d);
        int wd0 = wr_done_cnt;
        logic [VW-1:0] exp_vec;
        for (int s = 0; s < 20; s++) begin
            do_step(s);
            exp_vec = {(s >= 2) ? a : last_a,
                       (s >= 2) ? b : last_b,
                       (w && s >= 4) ? d : last_d,
                       (!w && (s == 6 || s == 7)),
                       (w && s == 8),
                       (w && s >= 6 && s <= 12),
                       (!w && s == 19)};
            checks++;
            if (out_vec !== exp_vec) begin
                errors++;
                $display("FAIL %s step %0d: outputs {A,B,din,ren,wen,rwb,rv}=%h, required %h",
                         tag, s, out_vec, exp_vec);
            end
        end
        checks++;
        if (wr_done_cnt !== wd0 + (w ? 1 : 0)) begin
            errors++;
            $display("FAIL %s wr_done pulses: got %0d, required %0d", tag, wr_done_cnt - wd0, w ? 1 : 0);
        end
        checks++;
        if (dbg_state !== (w ? IDLE : RESP)) begin
            errors++;
            $display("FAIL %s end state: got %0d, required %0d", tag, dbg_state, w ? IDLE : RESP);
        end
        last_a = a;
        last_b = b;
        if (w) last_d = d;
    endtask

    // Holds rsp_ready low for 'hold' cycles, then completes the response handshake.
    task automatic take_rsp(input string tag, input int hold);
        logic [2*DW-1:0] exp;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s scoreboard: got empty queue, required one expected read", tag);
            return;
        end
        exp = exp_q.pop_front();
        for (int i = 0; i <= hold; i++) begin
            checks++;
            if ({bus.rsp_valid, bus.rsp_data_a, bus.rsp_data_b, bus.req_ready} !== {1'b1, exp, 1'b0}) begin
                errors++;
                $display("FAIL %s rsp hold cycle %0d: {valid,a,b,ready}=%b_%h_%h_%b, required 1_%h_%h_0",
                         tag, i, bus.rsp_valid, bus.rsp_data_a, bus.rsp_data_b, bus.req_ready,
                         exp[2*DW-1:DW], exp[DW-1:0]);
            end
            if (i < hold) @(negedge clk);
        end
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        checks++;
        if ({bus.rsp_valid, bus.req_ready, dbg_state} !== {1'b0, 1'b1, IDLE}) begin
            errors++;
            $display("FAIL %s rsp release: valid=%b ready=%b state=%0d, required 0 1 %0d",
                     tag, bus.rsp_valid, bus.req_ready, dbg_state, IDLE);
        end
    endtask

    // scenarios
    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({out_vec, bus.rsp_data_a, bus.rsp_data_b, bus.wr_done, dbg_state} !== '0) begin
            errors++;
            $display("FAIL reset outputs: vec=%h rsp_a=%h rsp_b=%h wr_done=%b state=%0d, required all 0",
                     out_vec, bus.rsp_data_a, bus.rsp_data_b, bus.wr_done, dbg_state);
        end
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.req_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset req_ready: got %b, required 1", bus.req_ready);
        end
    endtask

    task automatic test_write();
        issue_req(1'b1, 5'd1, 5'd31, 16'hAAAA);
        run_frame("write", 1'b1, 5'd1, 5'd31, 16'hAAAA);
        checks++;
        if (bank[1] !== 16'hAAAA) begin
            errors++;
            $display("FAIL write bank[1]: got %h, required aaaa", bank[1]);
        end
    endtask

    task automatic test_read();
        issue_req(1'b0, 5'd1, 5'd0, 16'h0000);
        run_frame("read", 1'b0, 5'd1, 5'd0, 16'h0000);
        take_rsp("read", 0);
    endtask

    task automatic test_resp_hold();
        issue_req(1'b1, 5'd2, 5'd7, 16'h1234);
        run_frame("hold_wr", 1'b1, 5'd2, 5'd7, 16'h1234);
        issue_req(1'b0, 5'd2, 5'd1, 16'h0000);
        run_frame("hold_rd", 1'b0, 5'd2, 5'd1, 16'h0000);
        take_rsp("hold_rd", 30);
    endtask

    task automatic test_late_req();
        logic [VW-1:0] snap;
        logic [DW-1:0] d = DW'($urandom_range(0, 65535));
        for (int s = 0; s < 3; s++) do_step(s);
        snap = {last_a, last_b, last_d, 4'b0000};
        issue_req(1'b1, 5'd5, 5'd6, d);
        for (int s = 3; s < 20; s++) begin
            do_step(s);
            checks++;
            if ({out_vec, dbg_state} !== {snap, W_ADDR}) begin
                errors++;
                $display("FAIL late step %0d: vec=%h state=%0d, required %h state %0d",
                         s, out_vec, dbg_state, snap, W_ADDR);
            end
        end
        run_frame("late", 1'b1, 5'd5, 5'd6, d);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 6; i++) begin
            logic w = 1'($urandom_range(0, 1));
            logic [AW-1:0] a = AW'($urandom_range(0, 31));
            logic [AW-1:0] b = AW'($urandom_range(0, 31));
            logic [DW-1:0] d = DW'($urandom_range(0, 65535));
            if (i == 5) w = 1'b0;
            issue_req(w, a, b, d);
            run_frame("b2b", w, a, b, d);
            if (!w) take_rsp("b2b", $urandom_range(0, 3));
        end
    endtask

    task automatic test_reset_mid();
        int wd0;
        issue_req(1'b1, 5'd3, 5'd4, 16'h5555);
        for (int s = 0; s < 9; s++) do_step(s);
        checks++;
        if (WriteEn !== 1'b1) begin
            errors++;
            $display("FAIL midrst WriteEn before reset: got %b, required 1", WriteEn);
        end
        wd0 = wr_done_cnt;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checks++;
        if ({out_vec, bus.wr_done, dbg_state} !== '0) begin
            errors++;
            $display("FAIL midrst outputs: vec=%h wr_done=%b state=%0d, required all 0",
                     out_vec, bus.wr_done, dbg_state);
        end
        last_a = '0;
        last_b = '0;
        last_d = '0;
        for (int s = 9; s < 20; s++) begin
            do_step(s);
            checks++;
            if ({out_vec, dbg_state} !== '0) begin
                errors++;
                $display("FAIL midrst idle step %0d: vec=%h state=%0d, required 0", s, out_vec, dbg_state);
            end
        end
        checks++;
        if (wr_done_cnt !== wd0) begin
            errors++;
            $display("FAIL midrst wr_done: got %0d pulses, required 0", wr_done_cnt - wd0);
        end
        issue_req(1'b0, 5'd1, 5'd31, 16'h0000);
        run_frame("midrst_rd", 1'b0, 5'd1, 5'd31, 16'h0000);
        take_rsp("midrst_rd", 2);
    endtask

    initial begin
        bus.req_valid  = 1'b0;
        bus.req_write  = 1'b0;
        bus.req_addr_a = '0;
        bus.req_addr_b = '0;
        bus.req_wdata  = '0;
        bus.rsp_ready  = 1'b0;
        for (int i = 0; i < 32; i++) shadow[i] = '0;
        @(negedge clk);
        test_reset();
        test_write();
        test_read();
        test_resp_hold();
        test_late_req();
        test_back_to_back();
        test_reset_mid();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard drain: %0d entries left, required 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
